inst_asm_reg: RTL
=================

// Module: inst_asm_reg
// PURPOSE
//   Parametrised instruction-assembly register: collects NBEATS bus beats of
//   BUS_W bits into one INST_W-bit instruction word and presents it to the
//   decoder through a valid/ready output stage. It sits between program memory
//   and the controller. A second (assembly) buffer lets the fetch of the next
//   instruction overlap with a stalled consumer.
// PARAMETERS
//   BUS_W        8   width of one fetch beat (data port)
//   NBEATS       2   beats per instruction, >=1; INST_W = BUS_W*NBEATS
//   ABORT_ON_GAP 1   1: ena low mid-instruction discards partial word; 0: holds it
// PORTS
//   clk        in   1             rising-edge clock
//   rst        in   1             synchronous, active-high reset
//   flush      in   1             discard partial + buffered + output words
//   ena        in   1             beat strobe; beat accepted when ena & in_rdy
//   data       in   BUS_W         fetch beat
//   in_rdy     out  1             assembler can accept a beat
//   instr      out  INST_W        assembled instruction, beat 0 in MSBs
//   instr_vld  out  1             instr holds a valid word
//   instr_rdy  in   1             consumer takes instr when instr_vld & instr_rdy
//   beat_cnt   out  max(1,clog2(NBEATS))  index of next beat to capture
// BEHAVIOUR
//   Reset: beat_cnt=0, partial/asm buffers=0, asm_full=0, instr=0,
//     instr_vld=0; in_rdy=1 in the first cycle after reset.
//   Placement: beat k goes to asm[INST_W-1-k*BUS_W -: BUS_W] (MSB-first).
//   Counter: increments per accepted beat; wraps NBEATS-1 -> 0 on the final beat.
//   Final beat accepted, edge T:
//     - output free (!instr_vld, or instr_vld & instr_rdy at T):
//       instr <= word, instr_vld=1 after T (latency 1 cycle from final beat).
//     - otherwise word -> asm buffer, asm_full=1, in_rdy=0 after T.
//   Output consumed while asm_full: instr <= asm, instr_vld stays 1,
//     asm_full=0, in_rdy=1 next cycle. No bubble.
//   Consumed with nothing pending: instr_vld=0; instr keeps its old value.
//   in_rdy = !asm_full (combinational). Beats with in_rdy=0 are ignored, even
//     when ena=1.
//   Gap (ena=0, beat_cnt!=0):
//     - ABORT_ON_GAP=1: beat_cnt <= 0; bytes already captured are ignored.
//     - ABORT_ON_GAP=0: beat_cnt and partial bytes are held.
//   NBEATS=1: every accepted beat is a complete instruction; beat_cnt is tied 0.
//   flush: top priority over ena and instr_rdy in the same cycle. Clears
//     beat_cnt, asm_full and instr_vld; instr is held. A beat presented in the
//     flush cycle is dropped.
//   rst asserted mid-instruction: same end state as reset; no partial word
//     survives.
// CONFIGURATION
//   INST_ASM_PARITY_EN defined:
//     - Adds input data_par (1): even parity over data.
//     - Adds output instr_perr (1): set when any beat of the word in instr
//       failed parity.
//     - The error flag travels with the word through the asm buffer.
//     - Reset/flush clear it.
//   Not defined: both ports and all parity logic are absent.
// TESTING  (BUS_W=8, NBEATS=2, ABORT_ON_GAP=1 unless stated)
//   1 Beats 8'hA5, 8'h3C on consecutive cycles, instr_rdy=1
//     -> instr=16'hA53C, instr_vld=1 one cycle after 3C. Then instr_vld=0.
//   2 instr_rdy=0; words 1234 then 5678 -> instr=1234, in_rdy=0.
//     Then instr_rdy=1 for 1 cycle -> instr=5678 next cycle, in_rdy=1.
//   3 Beat 8'h11, ena=0 one cycle, then 22,33 -> instr=16'h2233.
//     With ABORT_ON_GAP=0 -> instr=16'h1122.
//   4 flush together with the final beat while asm_full=1
//     -> instr_vld=0, in_rdy=1, beat_cnt=0, no word delivered.
//   5 rst during beat_cnt=1 -> all outputs at reset values. Then BEEF
//     -> instr=16'hBEEF.
//   6 INST_ASM_PARITY_EN: beat 8'h01 with data_par=0 (parity mismatch)
//     -> instr_perr=1 with that word. Clean next word -> instr_perr=0.

Source files
------------

// File: rtl/inst_asm_if.sv
// Fetch/consumer bundle for the instruction-assembly register.
// Optional parity members are present only when INST_ASM_PARITY_EN is defined.
interface inst_asm_if #(
  parameter int BUS_W  = 8,
  parameter int NBEATS = 2
);
  localparam int INST_W = BUS_W * NBEATS;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic              flush;
  logic              ena;
  logic [BUS_W-1:0]  data;
  logic              in_rdy;
  logic [INST_W-1:0] instr;
  logic              instr_vld;
  logic              instr_rdy;
  logic [CNT_W-1:0]  beat_cnt;
`ifdef INST_ASM_PARITY_EN
  logic              data_par;
  logic              instr_perr;

  modport master (
    output flush, ena, data, instr_rdy, data_par,
    input  in_rdy, instr, instr_vld, beat_cnt, instr_perr
  );
  modport slave (
    input  flush, ena, data, instr_rdy, data_par,
    output in_rdy, instr, instr_vld, beat_cnt, instr_perr
  );
`else
  modport master (
    output flush, ena, data, instr_rdy,
    input  in_rdy, instr, instr_vld, beat_cnt
  );
  modport slave (
    input  flush, ena, data, instr_rdy,
    output in_rdy, instr, instr_vld, beat_cnt
  );
`endif
endinterface

// File: rtl/inst_asm_reg.sv
// Assembles NBEATS fetch beats (MSB-first) into one instruction with a one-deep
// overflow buffer ahead of a valid/ready output. Optional: INST_ASM_PARITY_EN.
module inst_asm_reg #(
  parameter int BUS_W        = 8,
  parameter int NBEATS       = 2,
  parameter int ABORT_ON_GAP = 1
) (
  input  logic        clk,
  input  logic        rst,
  inst_asm_if.slave   bus
);
  localparam int INST_W = BUS_W * NBEATS;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [INST_W-1:0] part_q, part_d;
  logic [INST_W-1:0] asm_q, asm_d;
  logic [INST_W-1:0] instr_q, instr_d;
  logic              asm_full_q, asm_full_d;
  logic              instr_vld_q, instr_vld_d;

  logic [INST_W-1:0] word;
  logic              acc, last_beat, take, out_free;
  logic              load_out, load_asm, pop_asm, drop_out;

  // A flush cycle accepts nothing; a full overflow buffer blocks every beat.
  assign acc       = bus.ena & ~asm_full_q & ~bus.flush;
  assign last_beat = (int'(beat_cnt_q) == NBEATS - 1);
  assign take      = instr_vld_q & bus.instr_rdy & ~bus.flush;
  assign out_free  = ~instr_vld_q | bus.instr_rdy;

  assign load_out  = acc & last_beat & out_free;
  assign load_asm  = acc & last_beat & ~out_free;
  assign pop_asm   = take & asm_full_q;
  assign drop_out  = take & ~asm_full_q & ~(acc & last_beat);

  always_comb begin
    word = part_q;
    for (int k = 0; k < NBEATS; k++) begin
      if (int'(beat_cnt_q) == k) word[INST_W-1-k*BUS_W -: BUS_W] = bus.data;
    end
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    part_d      = part_q;
    asm_d       = asm_q;
    instr_d     = instr_q;
    asm_full_d  = asm_full_q;
    instr_vld_d = instr_vld_q;

    if (acc) part_d = word;

    if (bus.flush) begin
      beat_cnt_d = '0;
    end else if (acc) begin
      beat_cnt_d = last_beat ? '0 : beat_cnt_q + CNT_W'(1);
    end else if (!bus.ena && ABORT_ON_GAP != 0) begin
      // Stale bytes stay in part_q but are overwritten before they can be used.
      beat_cnt_d = '0;
    end

    if (bus.flush) begin
      asm_full_d  = 1'b0;
      instr_vld_d = 1'b0;
    end else if (load_out) begin
      instr_d     = word;
      instr_vld_d = 1'b1;
    end else if (load_asm) begin
      asm_d       = word;
      asm_full_d  = 1'b1;
    end else if (pop_asm) begin
      instr_d     = asm_q;
      asm_full_d  = 1'b0;
    end else if (drop_out) begin
      instr_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      part_q      <= '0;
      asm_q       <= '0;
      instr_q     <= '0;
      asm_full_q  <= 1'b0;
      instr_vld_q <= 1'b0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      part_q      <= part_d;
      asm_q       <= asm_d;
      instr_q     <= instr_d;
      asm_full_q  <= asm_full_d;
      instr_vld_q <= instr_vld_d;
    end
  end

  assign bus.in_rdy    = ~asm_full_q;
  assign bus.instr     = instr_q;
  assign bus.instr_vld = instr_vld_q;
  assign bus.beat_cnt  = beat_cnt_q;

`ifdef INST_ASM_PARITY_EN
  logic beat_err, word_err;
  logic part_err_q, part_err_d;
  logic asm_err_q, asm_err_d;
  logic perr_q, perr_d;

  // Error flag accumulates across the beats of a word and follows the word.
  assign beat_err = ^{bus.data, bus.data_par};
  assign word_err = beat_err | ((beat_cnt_q != '0) & part_err_q);

  always_comb begin
    part_err_d = acc ? word_err : part_err_q;
    asm_err_d  = asm_err_q;
    perr_d     = perr_q;
    if (bus.flush) begin
      perr_d    = 1'b0;
      asm_err_d = 1'b0;
    end else if (load_out) begin
      perr_d    = word_err;
    end else if (load_asm) begin
      asm_err_d = word_err;
    end else if (pop_asm) begin
      perr_d    = asm_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      part_err_q <= 1'b0;
      asm_err_q  <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      part_err_q <= part_err_d;
      asm_err_q  <= asm_err_d;
      perr_q     <= perr_d;
    end
  end

  assign bus.instr_perr = perr_q;
`endif
endmodule
